pipeline_stall_ctrl: RTL and testbench
======================================

Name: pipeline_stall_ctrl

Overview:
- Central hazard and stall sequencer for the 5-stage CPU pipeline.
- Watches the ID-stage register read requests (read enables/addresses from the decode units), EX-stage load and divide activity, branch resolution and exception flushes.
- Drives a 6-bit per-stage stall vector plus flush strobes.
- Owns the only multi-cycle state in pipeline control: the divider wait window.

Parameters:
DIV_LATENCY, 32, max cycles to wait for div_done before forced release (timeout); legal 2..255
CNT_W, 8, width of divide wait counter; must hold DIV_LATENCY-1

Ports:
clk  input  1  pipeline clock
rst  input  1  reset, asynchronous, active-low (asserted at 0)
id_reg_read_en_1  input  1  ID read port 1 enable
id_reg_addr_1  input  5  ID read port 1 address
id_reg_read_en_2  input  1  ID read port 2 enable
id_reg_addr_2  input  5  ID read port 2 address
ex_mem_read  input  1  EX instruction is a load
ex_write_reg_en  input  1  EX instruction writes a GPR
ex_write_reg_addr  input  5  EX destination GPR
ex_div_start  input  1  EX holds DIV/DIVU, divider starting this cycle
div_done  input  1  divider result valid (single-cycle pulse)
ex_branch_taken  input  1  branch/jump resolved taken in EX
exc_flush  input  1  exception/eret flush request from MEM
stall  output  6  {wb,mem,ex,id,if,pc}; 1 = hold that stage
flush_id  output  1  kill instruction in IF/ID latch
flush_all  output  1  kill IF/ID, ID/EX, EX/MEM latches
ctrl_state  output  2  current FSM state (debug)
div_timeout  output  1  registered one-cycle pulse on divide timeout

Behaviour:
- Reset (rst=0, async): state=RUN, counter=0, div_timeout=0. Combinational outputs evaluate to stall=0, flush_id=0, flush_all=0.
- FSM states and encodings: RUN=2'd0, DIV_WAIT=2'd1, FLUSH=2'd2; 2'd3 is unused and recovers to RUN.
- Load-use detect, combinational: lu = ex_mem_read & ex_write_reg_en & (ex_write_reg_addr!=0) & ((id_reg_read_en_1 & id_reg_addr_1==ex_write_reg_addr) | (id_reg_read_en_2 & id_reg_addr_2==ex_write_reg_addr)).
- Load-use stall lasts exactly one cycle, with no state change. Forwarding from MEM covers the following cycle.
- Output priority per cycle, highest first:
  1. exc_flush: flush_all=1, stall=0, flush_id=0. Next state FLUSH from any state; counter cleared.
  2. DIV_WAIT & !div_done: stall=6'b001111.
  3. RUN & ex_div_start: stall=6'b001111. Counter <= DIV_LATENCY-1; next state DIV_WAIT.
  4. RUN & lu: stall=6'b000111 (EX receives bubble).
  5. RUN & ex_branch_taken: flush_id=1, stall=0.
  6. Otherwise: all zero.
- DIV_WAIT:
  - div_done=1 → stall=0 that same cycle; next state RUN.
  - Else if counter==0 → stall released; div_timeout<=1 for one cycle; next state RUN.
  - Else counter decrements each cycle.
- Stall cycles for a divide = 1 + number of DIV_WAIT cycles before div_done.
- FLUSH: one-cycle recovery state, all outputs 0; ex_div_start, lu and branch are ignored. Next state RUN unless exc_flush is asserted again.
- Counter width rule: DIV_LATENCY-1 is truncated to CNT_W. Violating the legal range is a configuration error, not handled.
- Simultaneous events:
  - div_done and exc_flush in the same cycle → flush wins.
  - ex_div_start with lu → div stall pattern wins.
  - div_done outside DIV_WAIT is ignored.

Optional Feature:
STALL_PERF_CNT_EN
- Defined: adds output stall_cycles [31:0]. It increments each cycle where stall[1] (IF) is 1, wraps at 2^32, and is cleared only by rst.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Load-use: ex_mem_read=1, ex_write_reg_addr=5, id_reg_read_en_1=1, id_reg_addr_1=5 → stall=6'b000111 for exactly 1 cycle; same stimulus with addr=0 → stall=0.
- Divide: ex_div_start at T, div_done at T+4 → stall=6'b001111 for T..T+3, stall=0 at T+4; ctrl_state=1 for T+1..T+4 and 0 at T+5.
- Timeout: DIV_LATENCY=8, div_done never asserted → stall held 1+8 cycles, div_timeout pulses 1 cycle, then ctrl_state=0.
- Exception mid-divide: exc_flush at 3rd DIV_WAIT cycle → flush_all=1, stall=0 that cycle; ctrl_state=2 next cycle, then 0.
- Branch: ex_branch_taken=1 in RUN → flush_id=1 for 1 cycle, stall=0.
- Async reset in DIV_WAIT: drop rst mid-cycle → ctrl_state=0 and stall=0 immediately, before the next clk edge; with STALL_PERF_CNT_EN, stall_cycles=0.

Source files
------------

// File: rtl/pipeline_stall_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipeline_stall_ctrl                                                        |
// | Hazard/stall sequencer: load-use, divider wait window, branch and          |
// | exception flushes. Optional macro STALL_PERF_CNT_EN adds stall_cycles.     |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module pipeline_stall_ctrl #(
    parameter int DIV_LATENCY = 32,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_reg_read_en_1,
    input  logic [4:0]       id_reg_addr_1,
    input  logic             id_reg_read_en_2,
    input  logic [4:0]       id_reg_addr_2,
    input  logic             ex_mem_read,
    input  logic             ex_write_reg_en,
    input  logic [4:0]       ex_write_reg_addr,
    input  logic             ex_div_start,
    input  logic             div_done,
    input  logic             ex_branch_taken,
    input  logic             exc_flush,
    output logic [5:0]       stall,
    output logic             flush_id,
    output logic             flush_all,
    output logic [1:0]       ctrl_state,
`ifdef STALL_PERF_CNT_EN
    output logic [31:0]      stall_cycles,
`endif
    output logic             div_timeout
);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_DIV_WAIT = 2'd1,
        S_FLUSH    = 2'd2,
        S_UNUSED   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_div_load  = CNT_W'(DIV_LATENCY - 1);
    localparam logic [5:0]       c_stall_div = 6'b001111;
    localparam logic [5:0]       c_stall_lu  = 6'b000111;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_timeout_nxt;
    logic             w_lu;

    assign w_lu = ex_mem_read & ex_write_reg_en & (ex_write_reg_addr != 5'd0) &
                  ((id_reg_read_en_1 & (id_reg_addr_1 == ex_write_reg_addr)) |
                   (id_reg_read_en_2 & (id_reg_addr_2 == ex_write_reg_addr)));

    always_comb begin
        stall         = 6'b0;
        flush_id      = 1'b0;
        flush_all     = 1'b0;
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_timeout_nxt = 1'b0;
        if (exc_flush) begin
            flush_all   = 1'b1;
            w_state_nxt = S_FLUSH;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (ex_div_start) begin
                        stall       = c_stall_div;
                        w_cnt_nxt   = c_div_load;
                        w_state_nxt = S_DIV_WAIT;
                    end else if (w_lu) begin
                        stall = c_stall_lu;
                    end else if (ex_branch_taken) begin
                        flush_id = 1'b1;
                    end
                end
                S_DIV_WAIT: begin
                    if (div_done) begin
                        w_state_nxt = S_RUN;
                    end else begin
                        // Stall holds through the counter==0 cycle; release is next cycle.
                        stall = c_stall_div;
                        if (r_cnt == '0) begin
                            w_timeout_nxt = 1'b1;
                            w_state_nxt   = S_RUN;
                        end else begin
                            w_cnt_nxt = r_cnt - CNT_W'(1);
                        end
                    end
                end
                S_FLUSH:  w_state_nxt = S_RUN;
                default:  w_state_nxt = S_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_RUN;
            r_cnt       <= '0;
            div_timeout <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            div_timeout <= w_timeout_nxt;
        end
    end

    assign ctrl_state = r_state;

`ifdef STALL_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= 32'd0;
        end else if (stall[1]) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_stall_ctrl.sv
`default_nettype none
// Testbench for pipeline_stall_ctrl: vector table plus hand sequences,
// expected outputs queued at drive time and checked on the falling edge.
module tb_pipeline_stall_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en1 = 0, en2 = 0, mrd = 0, wen = 0, dst = 0, ddn = 0, br = 0, exc = 0;
    logic [4:0] a1 = 0, a2 = 0, wa = 0;
    logic [5:0] stall;
    logic       flush_id, flush_all, div_timeout;
    logic [1:0] ctrl_state;
`ifdef STALL_PERF_CNT_EN
    logic [31:0] stall_cycles;
    int unsigned exp_perf = 0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipeline_stall_ctrl #(.DIV_LATENCY(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .id_reg_read_en_1(en1), .id_reg_addr_1(a1),
        .id_reg_read_en_2(en2), .id_reg_addr_2(a2),
        .ex_mem_read(mrd), .ex_write_reg_en(wen), .ex_write_reg_addr(wa),
        .ex_div_start(dst), .div_done(ddn), .ex_branch_taken(br), .exc_flush(exc),
        .stall(stall), .flush_id(flush_id), .flush_all(flush_all),
        .ctrl_state(ctrl_state),
`ifdef STALL_PERF_CNT_EN
        .stall_cycles(stall_cycles),
`endif
        .div_timeout(div_timeout)
    );

    typedef struct {
        logic       en1; logic [4:0] a1; logic en2; logic [4:0] a2;
        logic       mrd; logic wen; logic [4:0] wa;
        logic       dst; logic ddn; logic br; logic exc;
        logic [5:0] e_stall; logic e_fid; logic e_fall; logic [1:0] e_st; logic e_to;
    } vec_t;

    vec_t exp_q[$];

    function automatic vec_t mk(input logic i_en1, input logic [4:0] i_a1,
                                input logic i_en2, input logic [4:0] i_a2,
                                input logic i_mrd, input logic i_wen, input logic [4:0] i_wa,
                                input logic i_dst, input logic i_ddn, input logic i_br,
                                input logic i_exc, input logic [5:0] es, input logic fid,
                                input logic fall, input logic [1:0] st, input logic to);
        vec_t v;
        v.en1 = i_en1; v.a1 = i_a1; v.en2 = i_en2; v.a2 = i_a2;
        v.mrd = i_mrd; v.wen = i_wen; v.wa = i_wa;
        v.dst = i_dst; v.ddn = i_ddn; v.br = i_br; v.exc = i_exc;
        v.e_stall = es; v.e_fid = fid; v.e_fall = fall; v.e_st = st; v.e_to = to;
        return v;
    endfunction

    // Idle-input vector with given expected stall/state/timeout.
    function automatic vec_t idle(input logic [5:0] es, input logic [1:0] st, input logic to);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, es, 0, 0, st, to);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input vec_t v);
        @(posedge clk);
        #1;
        en1 = v.en1; a1 = v.a1; en2 = v.en2; a2 = v.a2;
        mrd = v.mrd; wen = v.wen; wa = v.wa;
        dst = v.dst; ddn = v.ddn; br = v.br; exc = v.exc;
        exp_q.push_back(v);
    endtask

    always @(negedge clk) begin
        vec_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("stall", 32'(stall), 32'(e.e_stall));
            chk("flush_id", 32'(flush_id), 32'(e.e_fid));
            chk("flush_all", 32'(flush_all), 32'(e.e_fall));
            chk("ctrl_state", 32'(ctrl_state), 32'(e.e_st));
            chk("div_timeout", 32'(div_timeout), 32'(e.e_to));
`ifdef STALL_PERF_CNT_EN
            chk("stall_cycles", stall_cycles, exp_perf);
            if (e.e_stall[1]) exp_perf++;
`endif
        end
    end

    vec_t tbl[16];

    initial begin
        tbl[0]  = idle(6'b0, 2'd0, 0);
        tbl[1]  = mk(1, 5, 0, 0, 1, 1, 5, 0, 0, 0, 0, 6'b000111, 0, 0, 2'd0, 0);
        tbl[2]  = idle(6'b0, 2'd0, 0);
        tbl[3]  = mk(1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 6'b0, 0, 0, 2'd0, 0);
        tbl[4]  = mk(0, 0, 1, 7, 1, 1, 7, 0, 0, 0, 0, 6'b000111, 0, 0, 2'd0, 0);
        tbl[5]  = mk(1, 5, 0, 0, 1, 0, 5, 0, 0, 0, 0, 6'b0, 0, 0, 2'd0, 0);
        tbl[6]  = mk(0, 5, 0, 0, 1, 1, 5, 0, 0, 0, 0, 6'b0, 0, 0, 2'd0, 0);
        tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 6'b0, 1, 0, 2'd0, 0);
        tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6'b0, 0, 1, 2'd0, 0);
        // FLUSH state ignores divide, load-use and branch.
        tbl[9]  = mk(1, 5, 0, 0, 1, 1, 5, 1, 0, 1, 0, 6'b0, 0, 0, 2'd2, 0);
        tbl[10] = idle(6'b0, 2'd0, 0);
        tbl[11] = mk(1, 3, 0, 0, 1, 1, 3, 1, 0, 0, 0, 6'b001111, 0, 0, 2'd0, 0);
        tbl[12] = idle(6'b001111, 2'd1, 0);
        tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 6'b0, 0, 0, 2'd1, 0);
        tbl[14] = idle(6'b0, 2'd0, 0);
        tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 6'b0, 0, 0, 2'd0, 0);

        #12;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_flush_id", 32'(flush_id), 32'd0);
        chk("rst_flush_all", 32'(flush_all), 32'd0);
        chk("rst_state", 32'(ctrl_state), 32'd0);
        chk("rst_timeout", 32'(div_timeout), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 16; i++) step(tbl[i]);

        // Divide finishing at T+4.
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 6'b001111, 0, 0, 2'd0, 0));
        for (int i = 0; i < 3; i++) step(idle(6'b001111, 2'd1, 0));
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 6'b0, 0, 0, 2'd1, 0));
        step(idle(6'b0, 2'd0, 0));

        // Timeout with DIV_LATENCY=8: 1+8 stalled cycles then a timeout pulse.
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 6'b001111, 0, 0, 2'd0, 0));
        for (int i = 0; i < 8; i++) step(idle(6'b001111, 2'd1, 0));
        step(idle(6'b0, 2'd0, 1));
        step(idle(6'b0, 2'd0, 0));

        // Exception (with simultaneous div_done) on the 3rd DIV_WAIT cycle.
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 6'b001111, 0, 0, 2'd0, 0));
        step(idle(6'b001111, 2'd1, 0));
        step(idle(6'b001111, 2'd1, 0));
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 6'b0, 0, 1, 2'd1, 0));
        step(idle(6'b0, 2'd2, 0));
        step(idle(6'b0, 2'd0, 0));

        // Async reset while in DIV_WAIT.
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 6'b001111, 0, 0, 2'd0, 0));
        step(idle(6'b001111, 2'd1, 0));
        @(negedge clk);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("async_rst_state", 32'(ctrl_state), 32'd0);
        chk("async_rst_stall", 32'(stall), 32'd0);
`ifdef STALL_PERF_CNT_EN
        chk("async_rst_perf", stall_cycles, 32'd0);
        exp_perf = 0;
`endif
        @(negedge clk);
        rst = 1'b1;
        step(idle(6'b0, 2'd0, 0));
        @(negedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
